// File: rtl/funcmon_pkg.sv
// Shared constants and record sizing for the function-monitor timestamp blocks.
// Pure declarations: no latency, no flow control.
package funcmon_pkg;
    localparam int N_CNT_DEF = 64;
    localparam int N_drop    = 16;

    // Record layout is {id, ts}, id in the upper bits.
    function automatic int rec_width(input int n_id, input int n_cnt);
        return n_id + n_cnt;
    endfunction
endpackage

// File: rtl/ts_fifo.sv
// Generic show-ahead synchronous FIFO; dout shows the head combinationally, push lands next cycle.
// Push is ignored when full, pop is ignored when empty; level is a separate counter.
module ts_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/event_timestamp_fifo.sv
// Timestamps rising edges per channel, arbitrates lowest pending channel into a show-ahead FIFO.
// Edge at k -> FIFO write at k+1; a full FIFO stalls pending records, repeat edges while pending are dropped and counted.
module event_timestamp_fifo
    import funcmon_pkg::*;
#(
    parameter int N_cnt = N_CNT_DEF,
    parameter int N_ch  = 4,
    parameter int DEPTH = 16,
    parameter int N_id  = $clog2(N_ch)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_ch-1:0]          ev_in,
    input  logic [N_cnt-1:0]         timestamp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_id-1:0]          out_id,
    output logic [N_cnt-1:0]         out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [N_drop-1:0]        drop_cnt,
    input  logic                     clear_overflow
);
    localparam int REC_W = rec_width(N_id, N_cnt);

    logic [N_ch-1:0]  ev_q;
    logic [N_ch-1:0]  pend;
    logic [N_cnt-1:0] ts_hold [N_ch];
    logic [N_ch-1:0]  rise;
    logic [N_ch-1:0]  gnt_oh;
    logic [N_ch-1:0]  drop_vec;
    logic [N_id-1:0]  gnt_idx;
    logic             wr_en;
    logic             full;
    logic             empty;
    logic [REC_W-1:0] din;
    logic [REC_W-1:0] dout;
    logic [N_drop:0]  drop_sum;
    logic [N_drop-1:0] drop_nxt;

    assign rise  = ev_in & ~ev_q;
    assign wr_en = (|pend) & ~full;

    // Descending scan so the lowest pending index wins.
    always_comb begin
        gnt_idx = '0;
        for (int c = N_ch - 1; c >= 0; c--) begin
            if (pend[c]) gnt_idx = N_id'(c);
        end
        gnt_oh = '0;
        if (wr_en) gnt_oh[gnt_idx] = 1'b1;
    end

    // A rise on the channel being written this cycle is re-captured, not dropped.
    assign drop_vec = rise & pend & ~gnt_oh;

    always_comb begin
        drop_sum = {1'b0, (clear_overflow ? {N_drop{1'b0}} : drop_cnt)};
        for (int c = 0; c < N_ch; c++) begin
            drop_sum = drop_sum + (N_drop+1)'(drop_vec[c]);
        end
        drop_nxt = drop_sum[N_drop] ? {N_drop{1'b1}} : drop_sum[N_drop-1:0];
    end

    assign din = {gnt_idx, ts_hold[gnt_idx]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ev_q     <= '0;
            pend     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            for (int c = 0; c < N_ch; c++) ts_hold[c] <= '0;
        end else begin
            ev_q     <= ev_in;
            drop_cnt <= drop_nxt;
            overflow <= (overflow & ~clear_overflow) | (|drop_vec);
            for (int c = 0; c < N_ch; c++) begin
                if (rise[c] && (!pend[c] || gnt_oh[c])) begin
                    pend[c]    <= 1'b1;
                    ts_hold[c] <= timestamp;
                end else if (gnt_oh[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    ts_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (wr_en),
        .din     (din),
        .pop     (out_ready),
        .dout    (dout),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = ~empty;
    assign out_id    = dout[REC_W-1 -: N_id];
    assign out_ts    = dout[N_cnt-1:0];
endmodule

// File: tb/tb_event_timestamp_fifo.sv
// Directed bench for event_timestamp_fifo with a record scoreboard drained by a negedge monitor.
module tb_event_timestamp_fifo;
    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] ts;
    } rec_t;

    logic        clock;
    logic        reset_n;
    logic [3:0]  ev_in;
    logic [63:0] timestamp;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [63:0] out_ts;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clear_overflow;

    rec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    event_timestamp_fifo #(
        .N_cnt (64),
        .N_ch  (4),
        .DEPTH (16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ev_in          (ev_in),
        .timestamp      (timestamp),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_id         (out_id),
        .out_ts         (out_ts),
        .level          (level),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .clear_overflow (clear_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_rec(input logic [1:0] id, input logic [63:0] ts);
        rec_t r;
        r.id = id;
        r.ts = ts;
        sb.push_back(r);
    endtask

    // Monitor: compare every accepted head record against the scoreboard.
    initial begin
        rec_t e;
        forever begin
            @(negedge clock);
            if (reset_n && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_record: got id=%0d ts=%0d, expected none", out_id, out_ts);
                end else begin
                    e = sb.pop_front();
                    if (out_id !== e.id || out_ts !== e.ts) begin
                        errors++;
                        $display("FAIL record: got id=%0d ts=%0d expected id=%0d ts=%0d",
                                 out_id, out_ts, e.id, e.ts);
                    end
                end
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        ev_in          = '0;
        timestamp      = '0;
        out_ready      = 1'b1;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("reset_level", 64'(level), 0);
        chk("reset_valid", 64'(out_valid), 0);
        chk("reset_overflow", 64'(overflow), 0);
        chk("reset_drop_cnt", 64'(drop_cnt), 0);
        tick();

        // Single event on channel 2
        ev_in = 4'b0100; timestamp = 100; expect_rec(2, 100);
        tick();
        ev_in = '0;
        tick();
        chk("single_valid_hi", 64'(out_valid), 1);
        tick();
        chk("single_valid_lo", 64'(out_valid), 0);

        // Simultaneous edges on 0,1,3
        ev_in = 4'b1011; timestamp = 50;
        expect_rec(0, 50); expect_rec(1, 50); expect_rec(3, 50);
        tick();
        ev_in = '0;
        repeat (6) tick();

        // Fill and backpressure on channel 0
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ev_in = 4'b0001; timestamp = 64'(200 + i); expect_rec(0, 64'(200 + i));
            tick();
            ev_in = '0;
            tick();
        end
        chk("full_level", 64'(level), 16);
        chk("full_overflow", 64'(overflow), 0);
        ev_in = 4'b0001; timestamp = 999;
        tick();
        ev_in = '0;
        tick();
        chk("drop_cnt_18th", 64'(drop_cnt), 1);
        chk("overflow_18th", 64'(overflow), 1);
        out_ready = 1'b1;
        repeat (25) tick();
        chk("drain_all", 64'(sb.size()), 0);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clear_overflow_a", 64'(overflow), 0);
        chk("clear_drop_cnt_a", 64'(drop_cnt), 0);

        // Re-capture on the write cycle of channel 1
        ev_in = 4'b0011; timestamp = 300;
        expect_rec(0, 300); expect_rec(1, 300); expect_rec(1, 310);
        tick();
        ev_in = '0;
        tick();
        ev_in = 4'b0010; timestamp = 310;
        tick();
        ev_in = '0;
        repeat (5) tick();
        chk("recapture_no_drop", 64'(drop_cnt), 0);
        chk("recapture_sb", 64'(sb.size()), 0);

        // Clear in the same cycle as a drop on channel 3
        ev_in = 4'b1110; timestamp = 400;
        expect_rec(1, 400); expect_rec(2, 400); expect_rec(3, 400);
        tick();
        ev_in = '0;
        tick();
        ev_in = 4'b1000; timestamp = 410; clear_overflow = 1'b1;
        tick();
        ev_in = '0; clear_overflow = 1'b0;
        chk("clr_drop_overflow", 64'(overflow), 1);
        chk("clr_drop_cnt", 64'(drop_cnt), 1);
        repeat (4) tick();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr_alone_overflow", 64'(overflow), 0);
        chk("clr_alone_cnt", 64'(drop_cnt), 0);

        // Async reset with entries buffered and ev_in[0] held high
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ev_in = 4'b0010; timestamp = 64'(500 + i);
            tick();
            ev_in = '0;
            tick();
        end
        ev_in = 4'b0001;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_level", 64'(level), 0);
        chk("arst_valid", 64'(out_valid), 0);
        sb.delete();
        tick();
        reset_n = 1'b1; timestamp = 777; out_ready = 1'b1;
        expect_rec(0, 777);
        repeat (5) tick();
        chk("post_reset_sb", 64'(sb.size()), 0);
        ev_in = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/event_timestamp_fifo.md
# event_timestamp_fifo

Captures rising edges on up to N_ch monitored event lines, tags each with the free-running timestamp value from the upstream `counter` and with its channel index, and buffers the records in a show-ahead FIFO. Downstream readout logic drains the FIFO through a valid/ready handshake. Per-channel pending registers absorb simultaneous edges, and lost events are counted and flagged.

## Interface
- `N_cnt`, 64, timestamp width; matches `counter` output width
- `N_ch`, 4, number of event channels, ≥2
- `DEPTH`, 16, FIFO entries, power of 2, ≥2
- `N_id`, $clog2(N_ch), channel-index width (derived)
- `clock`  in  1  single clock for all logic
- `reset_n`  in  1  asynchronous, active-low reset
- `ev_in`  in  N_ch  event lines, synchronous to `clock`
- `timestamp`  in  N_cnt  current `counter_q` value
- `out_valid`  out  1  FIFO head holds a record
- `out_ready`  in  1  consumer accepts head
- `out_id`  out  N_id  channel index of head record
- `out_ts`  out  N_cnt  timestamp of head record
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky: at least one event dropped
- `drop_cnt`  out  16  dropped events, saturating at 16'hFFFF
- `clear_overflow`  in  1  single-cycle pulse, clears `overflow` and `drop_cnt`

## Operation
- Edge detect: `ev_q` holds the previous `ev_in` sample. `rise[c] = ev_in[c] & ~ev_q[c]`.
- Capture, per channel: if `rise[c]` and `pend[c]==0`, set `pend[c]` and load `ts_hold[c] <= timestamp`.
- Capture while pending: if `rise[c]` and `pend[c]==1` and channel c is not being written this cycle:
  - the event is dropped;
  - `drop_cnt` increments, saturating;
  - `overflow` is set to 1.
- Arbitration: if any `pend` is set and `level < DEPTH` (registered value), write `{c, ts_hold[c]}` for the lowest pending index c and clear `pend[c]`. At most one write per cycle.
- Same-cycle edge on the channel being written: the new edge is captured. `pend[c]` stays 1 and `ts_hold[c]` is reloaded. This is not a drop.
- Pop: when `out_valid && out_ready`, advance the read pointer. `out_valid = (level != 0)`. `out_id`/`out_ts` present `mem[rd_ptr]` combinationally.
- Full FIFO: a write is blocked when registered `level == DEPTH`, even if a pop occurs in the same cycle. Pending records wait; they are not dropped.
- Simultaneous push and pop: `level` is unchanged.
- Pointers: `$clog2(DEPTH)` bits, wrap naturally. `level` is a separate counter.
- `clear_overflow`: clears `overflow` and `drop_cnt`. A drop in the same cycle wins, giving `overflow=1`, `drop_cnt=1`.
- Timestamp wrap is not interpreted. The value is stored as-is.

## Timing
- Reset (async assert) forces:
  - `pend`, `ev_q`, `ts_hold`, pointers, `level`, `overflow`, `drop_cnt` = 0;
  - hence `out_valid=0` and `level=0`;
  - `out_id`/`out_ts` are don't-care while `out_valid=0`.
- Because `ev_q` resets to 0, a line already high at reset release registers one event on the first active edge.
- Latency: edge sampled at clock k → `pend` set and `ts_hold` = `timestamp` sampled at k → FIFO write at k+1 (if arbitration won and not full) → `out_valid` high after k+1.
- Throughput: one write and one read per cycle.
- Reset mid-operation discards all pending and buffered records.

## Structure
- Shared package `funcmon_pkg` holds:
  - default `N_cnt`;
  - the record type `{id, ts}`, or its width function;
  - the `drop_cnt` width constant `N_drop = 16`.
- Sub-module `ts_fifo`: generic show-ahead synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, din, pop, dout, level, full, empty.
- Edge detect, pending registers and arbiter stay in the top module.

## Test plan
- Single event: pulse `ev_in[2]` at clock k with `timestamp=100`, `out_ready=1` → one record with `out_id=2`, `out_ts=100`; `out_valid` high for exactly one cycle after k+1.
- Simultaneous edges: `ev_in=4'b1011` at `timestamp=50` → records emitted in order id 0, 1, 3, all with `ts=50`, on consecutive cycles.
- Fill and backpressure: `out_ready=0`, 17 spaced events on channel 0 (`DEPTH=16`):
  - expect `level=16`, one event held in `pend`, `overflow=0`;
  - an 18th edge causes `drop_cnt=1`, `overflow=1`;
  - releasing `out_ready` delivers 17 records in order.
- Re-capture on write cycle: an edge on channel 1 in the same cycle its pending record is written → two records, no drop.
- Clear vs drop: `clear_overflow` in the same cycle as a drop → `overflow=1`, `drop_cnt=1`. A later `clear_overflow` alone → both 0.
- Async reset with 5 entries buffered and `ev_in[0]` held high → `level=0` and `out_valid=0` immediately. After release, one record with id 0.
